// File: rtl/dct_ch_arbiter.sv
// Block-granular arbiter sharing one forward-DCT row datapath between N_CH pixel sources.
// Optional build macro DCT_ARB_STRICT_PRIO_EN selects fixed priority (channel 0 highest) instead of round robin.
module dct_ch_arbiter #(
  parameter int N_CH      = 3,
  parameter int W_I       = 8,
  parameter int TAG_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH-1:0]         req_valid,
  output logic [N_CH-1:0]         req_ready,
  input  logic [N_CH*8*W_I-1:0]   req_data,
  input  logic [N_CH-1:0]         req_sof,
  output logic                    dct_valid,
  output logic [8*W_I-1:0]        dct_data,
  output logic                    dct_sob,
  output logic                    dct_eob,
  output logic                    dct_sof,
  input  logic                    ret_valid,
  input  logic                    ret_sob,
  output logic [$clog2(N_CH)-1:0] ret_ch,
  output logic                    tag_err,
  output logic                    busy
);

  localparam int CW = $clog2(N_CH);
  localparam int RW = 8 * W_I;
  localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int NW = $clog2(TAG_DEPTH) + 1;
  localparam logic [NW-1:0] DEPTH_C  = NW'(TAG_DEPTH);
  localparam logic [CW-1:0] LAST_CH  = CW'(N_CH - 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(TAG_DEPTH - 1);

  typedef enum logic {S_IDLE = 1'b0, S_XFER = 1'b1} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_gnt, w_sel;
  logic            w_any, w_grant, w_acc, w_push, w_pop, w_ret_sob;
  logic [2:0]      r_row_cnt;
  logic [RW-1:0]   w_row;
  logic [CW-1:0]   r_tag [TAG_DEPTH];
  logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [NW-1:0]   r_count;
  logic [CW-1:0]   r_cur_ch;
  logic            r_tag_err;

`ifdef DCT_ARB_STRICT_PRIO_EN
  // Fixed priority: lowest requesting index wins.
  always_comb begin
    w_sel = '0;
    w_any = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      w_sel = (!w_any && req_valid[i]) ? CW'(i) : w_sel;
      w_any = w_any | req_valid[i];
    end
  end
`else
  logic [CW-1:0] r_rr_ptr;

  // Round robin: first requester at or after r_rr_ptr, modulo N_CH.
  always_comb begin
    int j;
    j     = 0;
    w_sel = '0;
    w_any = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      j     = (int'(r_rr_ptr) + k) % N_CH;
      w_sel = (!w_any && req_valid[j]) ? CW'(j) : w_sel;
      w_any = w_any | req_valid[j];
    end
  end

  // Pointer moves past the channel just granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (w_grant) begin
      r_rr_ptr <= (w_sel == LAST_CH) ? '0 : w_sel + CW'(1);
    end
  end
`endif

  assign w_acc     = (r_state == S_XFER) && req_valid[r_gnt];
  assign w_grant   = (r_state == S_IDLE) && (w_state_nxt == S_XFER);
  assign w_ret_sob = ret_valid & ret_sob;
  assign w_push    = w_acc && (r_row_cnt == 3'd0);
  assign w_pop     = w_ret_sob && (r_count != '0);

  // Next-state logic; a grant waits until the tag FIFO has room.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = (w_any && (r_count < DEPTH_C)) ? S_XFER : S_IDLE;
      S_XFER:  w_state_nxt = (w_acc && (r_row_cnt == 3'd7)) ? S_IDLE : S_XFER;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Ready decode and selected-row mux.
  always_comb begin
    req_ready = '0;
    w_row     = '0;
    for (int i = 0; i < N_CH; i++) begin
      req_ready[i] = (r_state == S_XFER) && (r_gnt == CW'(i));
      w_row        = (r_gnt == CW'(i)) ? req_data[i*RW +: RW] : w_row;
    end
  end

  // State, grant and row counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_gnt     <= '0;
      r_row_cnt <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) r_gnt <= w_sel;
      if (w_acc)   r_row_cnt <= r_row_cnt + 3'd1;
    end
  end

  // Registered DCT-side outputs; data holds between rows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dct_valid <= 1'b0;
      dct_sob   <= 1'b0;
      dct_eob   <= 1'b0;
      dct_sof   <= 1'b0;
      dct_data  <= '0;
    end else begin
      dct_valid <= w_acc;
      dct_sob   <= w_acc && (r_row_cnt == 3'd0);
      dct_eob   <= w_acc && (r_row_cnt == 3'd7);
      dct_sof   <= w_acc && (r_row_cnt == 3'd0) && req_sof[r_gnt];
      if (w_acc) dct_data <= w_row;
    end
  end

  // In-order tag FIFO of granted channels; a pop with nothing queued flags tag_err instead.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_cur_ch  <= '0;
      r_tag_err <= 1'b0;
      for (int i = 0; i < TAG_DEPTH; i++) r_tag[i] <= '0;
    end else begin
      if (w_push) begin
        r_tag[r_wr_ptr] <= r_gnt;
        r_wr_ptr        <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_cur_ch <= r_tag[r_rd_ptr];
        r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + NW'(1);
        2'b01:   r_count <= r_count - NW'(1);
        default: r_count <= r_count;
      endcase
      if (w_ret_sob && (r_count == '0)) r_tag_err <= 1'b1;
    end
  end

  assign ret_ch  = ret_sob ? r_tag[r_rd_ptr] : r_cur_ch;
  assign tag_err = r_tag_err;
  assign busy    = (r_state == S_XFER) || (r_count != '0);

endmodule

// File: tb/tb_dct_ch_arbiter.sv
// Self-checking bench for dct_ch_arbiter: source models feed a row scoreboard, a tag model
// predicts ret_ch/tag_err, and hand sequences cover contention, stall, tag-full and reset.
module tb_dct_ch_arbiter;
  localparam int N_CH = 3;
  localparam int W_I  = 8;
  localparam int TAG_DEPTH = 4;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [N_CH-1:0]       req_valid = '0;
  logic [N_CH-1:0]       req_ready;
  logic [N_CH*64-1:0]    req_data = '0;
  logic [N_CH-1:0]       req_sof = '0;
  logic                  dct_valid, dct_sob, dct_eob, dct_sof;
  logic [63:0]           dct_data;
  logic                  ret_valid = 1'b0;
  logic                  ret_sob = 1'b0;
  logic [1:0]            ret_ch;
  logic                  tag_err, busy;

  dct_ch_arbiter #(.N_CH(N_CH), .W_I(W_I), .TAG_DEPTH(TAG_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data), .req_sof(req_sof),
    .dct_valid(dct_valid), .dct_data(dct_data), .dct_sob(dct_sob), .dct_eob(dct_eob), .dct_sof(dct_sof),
    .ret_valid(ret_valid), .ret_sob(ret_sob), .ret_ch(ret_ch), .tag_err(tag_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] d; logic sob; logic eob; logic sof; } exp_t;
  typedef struct { logic rv; logic rsob; logic [1:0] exp_ch; logic exp_busy; } ret_vec_t;

  exp_t sbq[$];
  int   gnt_log[$];
  int   tag_model[$];
  logic err_model;
  int   src_row[N_CH], src_blk[N_CH], src_left[N_CH];
  bit   src_en[N_CH], src_sof[N_CH];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [63:0] row_of(int c, int b, int r);
    logic [63:0] v;
    for (int k = 0; k < 8; k++) v[k*8 +: 8] = 8'(((c * 64) + ((b % 8) * 8) + r) ^ (k * 37));
    return v;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic drive_inputs();
    for (int c = 0; c < N_CH; c++) begin
      req_valid[c]        = src_en[c] && (src_left[c] > 0);
      req_data[c*64 +: 64] = row_of(c, src_blk[c], src_row[c]);
      req_sof[c]          = src_sof[c];
    end
  endtask

  task automatic clear_models();
    sbq.delete(); gnt_log.delete(); tag_model.delete();
    err_model = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      src_row[c] = 0; src_blk[c] = 0; src_left[c] = 0; src_en[c] = 1'b0; src_sof[c] = 1'b0;
    end
    ret_valid = 1'b0; ret_sob = 1'b0;
    drive_inputs();
  endtask

  // One clock: record accepts, advance, check the registered DCT row and tag_err.
  task automatic step();
    logic [N_CH-1:0] acc;
    exp_t e;
    acc = req_valid & req_ready;
    if (ret_valid && ret_sob) begin
      if (tag_model.size() > 0) void'(tag_model.pop_front());
      else err_model = 1'b1;
    end
    for (int c = 0; c < N_CH; c++) if (acc[c]) begin
      e.d = row_of(c, src_blk[c], src_row[c]);
      e.sob = (src_row[c] == 0); e.eob = (src_row[c] == 7); e.sof = (src_row[c] == 0) && src_sof[c];
      sbq.push_back(e);
      if (src_row[c] == 0) begin gnt_log.push_back(c); tag_model.push_back(c); end
    end
    @(posedge clk); @(negedge clk);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("dct_valid", 64'(dct_valid), 64'd1);
      chk("dct_data", dct_data, e.d);
      chk("dct_sob", 64'(dct_sob), 64'(e.sob));
      chk("dct_eob", 64'(dct_eob), 64'(e.eob));
      chk("dct_sof", 64'(dct_sof), 64'(e.sof));
    end else begin
      chk("dct_idle", 64'(dct_valid), 64'd0);
    end
    chk("tag_err", 64'(tag_err), 64'(err_model));
    for (int c = 0; c < N_CH; c++) if (acc[c]) begin
      src_row[c]++;
      if (src_row[c] == 8) begin src_row[c] = 0; src_blk[c]++; src_left[c]--; src_sof[c] = 1'b0; end
    end
    drive_inputs();
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk_outs_zero(string nm);
    chk(nm, {dct_data, 64'(dct_valid), 64'(dct_sob)} == '0 ? 64'(0) : 64'(1), 64'd0);
    chk({nm, "_ctl"}, 64'({dct_eob, dct_sof, req_ready, ret_ch, tag_err, busy}), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_models();
    @(posedge clk); @(negedge clk);
    chk_outs_zero("reset_out");
    rst = 1'b0;
  endtask

  ret_vec_t rtab[9];
  int exp_order[5];
  logic [2:0] exp_ready5;

  initial begin
    rtab[0] = '{1'b1, 1'b1, 2'd1, 1'b1};
    for (int i = 1; i < 8; i++) rtab[i] = '{1'b1, 1'b0, 2'd1, 1'b0};
    rtab[8] = '{1'b0, 1'b0, 2'd1, 1'b0};
`ifdef DCT_ARB_STRICT_PRIO_EN
    exp_order = '{0, 0, 0, 0, 0};
    exp_ready5 = 3'b001;
`else
    exp_order = '{0, 1, 2, 0, 1};
    exp_ready5 = 3'b010;
`endif

    // Single channel block with sof, then returned rows labelled from the table.
    do_reset();
    src_en[1] = 1'b1; src_left[1] = 1; src_sof[1] = 1'b1; drive_inputs();
    steps(10);
    chk("single_gnt_cnt", 64'(gnt_log.size()), 64'd1);
    chk("single_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 9; i++) begin
      ret_valid = rtab[i].rv; ret_sob = rtab[i].rsob;
      #1;
      chk($sformatf("ret_vec%0d_ch", i), 64'(ret_ch), 64'(rtab[i].exp_ch));
      chk($sformatf("ret_vec%0d_busy", i), 64'(busy), 64'(rtab[i].exp_busy));
      step();
    end

    // Contention with no returns: four blocks fill the tag FIFO, then one return frees a slot.
    do_reset();
    for (int c = 0; c < N_CH; c++) begin src_en[c] = 1'b1; src_left[c] = 10; src_sof[c] = 1'b1; end
    drive_inputs();
    steps(40);
    chk("full_gnt_cnt", 64'(gnt_log.size()), 64'd4);
    for (int i = 0; i < gnt_log.size() && i < 4; i++) chk($sformatf("order%0d", i), 64'(gnt_log[i]), 64'(exp_order[i]));
    chk("full_ready", 64'(req_ready), 64'd0);
    chk("full_busy", 64'(busy), 64'd1);
    ret_valid = 1'b1; ret_sob = 1'b1;
    #1;
    chk("full_ret_ch", 64'(ret_ch), 64'd0);
    step();
    ret_valid = 1'b0; ret_sob = 1'b0;
    chk("full_ready_t1", 64'(req_ready), 64'd0);
    step();
    chk("full_ready_t2", 64'(req_ready), 64'(exp_ready5));
    steps(9);
    chk("full_gnt5_cnt", 64'(gnt_log.size()), 64'd5);
    if (gnt_log.size() == 5) chk("order4", 64'(gnt_log[4]), 64'(exp_order[4]));

    // Simultaneous push and pop with two tags outstanding.
    do_reset();
    src_en[0] = 1'b1; src_left[0] = 2; drive_inputs();
    steps(19);
    chk("pp_gnt_cnt", 64'(gnt_log.size()), 64'd2);
    src_en[1] = 1'b1; src_left[1] = 1; drive_inputs();
    step();
    chk("pp_ready", 64'(req_ready), 64'b010);
    for (int i = 0; i < 3; i++) begin
      ret_valid = 1'b1; ret_sob = 1'b1;
      #1;
      chk($sformatf("pp_ret_ch%0d", i), 64'(ret_ch), (i == 2) ? 64'd1 : 64'd0);
      step();
      ret_valid = 1'b0; ret_sob = 1'b0;
    end
    steps(9);
    chk("pp_busy_end", 64'(busy), 64'd0);

    // Mid-block stall of ch2 while ch0 waits.
    do_reset();
    src_en[2] = 1'b1; src_left[2] = 1; drive_inputs();
    steps(5);
    src_en[2] = 1'b0; src_en[0] = 1'b1; src_left[0] = 1; drive_inputs();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall_ready%0d", i), 64'(req_ready), 64'b100);
      step();
    end
    src_en[2] = 1'b1; drive_inputs();
    steps(14);
    chk("stall_gnt_cnt", 64'(gnt_log.size()), 64'd2);
    if (gnt_log.size() == 2) begin
      chk("stall_gnt0", 64'(gnt_log[0]), 64'd2);
      chk("stall_gnt1", 64'(gnt_log[1]), 64'd0);
    end

    // Reset after row 4, then an orphan return and a fresh grant from channel 0.
    do_reset();
    src_en[1] = 1'b1; src_left[1] = 1; drive_inputs();
    steps(6);
    rst = 1'b1;
    #1;
    chk_outs_zero("midrst_out");
    clear_models();
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    ret_valid = 1'b1; ret_sob = 1'b1;
    step();
    ret_valid = 1'b0; ret_sob = 1'b0;
    chk("midrst_tag_err", 64'(tag_err), 64'd1);
    src_en[0] = 1'b1; src_left[0] = 1; src_en[2] = 1'b1; src_left[2] = 1; drive_inputs();
    steps(20);
    chk("midrst_gnt_cnt", 64'(gnt_log.size()), 64'd2);
    if (gnt_log.size() == 2) begin
      chk("midrst_gnt0", 64'(gnt_log[0]), 64'd0);
      chk("midrst_gnt1", 64'(gnt_log[1]), 64'd2);
    end
    chk("sb_drained", 64'(sbq.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dct_ch_arbiter.md
Name: dct_ch_arbiter

Overview:
- Block-granular arbiter that shares one forward-DCT datapath (dct_ft, 8 pixels per row, 8 rows per block, sob/eob/sof framing) between N_CH pixel sources, e.g. Y/Cb/Cr.
- Grants one channel for a whole 8-row block, then re-arbitrates, so blocks are never interleaved.
- Keeps an in-order tag FIFO of granted channels and labels blocks leaving the DCT pipeline, so the downstream demux/quantizer knows which channel each output row belongs to.

Parameters:
- N_CH, 3: number of requesting channels (2..8).
- W_I, 8: pixel width, matches dct_ft W_I.
- TAG_DEPTH, 4: maximum number of blocks granted but not yet returned from the DCT (power of 2).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  N_CH  per-channel row valid
- req_ready  out  N_CH  per-channel row accept
- req_data  in  N_CH*8*W_I  per-channel row; channel i occupies slice i
- req_sof  in  N_CH  start-of-frame; sampled on row 0 only
- dct_valid  out  1  row valid to dct_ft in_valid
- dct_data  out  8*W_I  row to dct_ft in_data
- dct_sob  out  1  first row of block
- dct_eob  out  1  last row of block
- dct_sof  out  1  first block of frame
- ret_valid  in  1  dct output out_valid
- ret_sob  in  1  dct output out_sob
- ret_ch  out  $clog2(N_CH)  channel of the row currently on ret_*
- tag_err  out  1  sticky: ret_sob seen with tag FIFO empty
- busy  out  1  state XFER or tag FIFO non-empty

Behaviour:
- States:
  - IDLE: if tag count < TAG_DEPTH and any req_valid, choose gnt, then go to XFER.
  - XFER: req_ready[gnt]=1, all other req_ready bits 0. row_cnt (3 bit) increments on each accept (req_valid[gnt] & req_ready[gnt]). The accept with row_cnt==7 returns to IDLE.
  - req_ready is 0 in IDLE. Each block therefore costs 8 accept cycles plus 1 IDLE cycle; dct_ft tolerates the gaps.
- Round robin: rr_ptr resets to 0. gnt is the first i with req_valid[i] searching rr_ptr, rr_ptr+1, ... modulo N_CH. On entering XFER, rr_ptr <= gnt+1 (wraps N_CH-1 -> 0).
- Output register: 1-cycle latency. On an accept:
  - dct_valid<=1, dct_data<=slice gnt
  - dct_sob<=(row_cnt==0), dct_eob<=(row_cnt==7)
  - dct_sof<=(row_cnt==0)&req_sof[gnt]
  - Otherwise all dct_* outputs <=0 (dct_data holds its value).
- Source stall mid-block (req_valid[gnt]=0): the grant holds, with no timeout. Other channels wait.
- Tag FIFO:
  - Push gnt on the row-0 accept.
  - Pop on ret_valid & ret_sob.
  - Simultaneous push and pop: count unchanged. Grant is only issued when count < TAG_DEPTH, so no overflow is possible.
- ret_ch:
  - Combinational: FIFO head when ret_sob=1, otherwise cur_ch.
  - cur_ch <= head on pop.
  - Only meaningful when ret_valid=1.
- tag_err: set on ret_valid & ret_sob with count==0. No pop occurs; cleared only by rst.
- Reset values (rst asserted at any time, including mid-block):
  - State IDLE; row_cnt, rr_ptr, cur_ch, FIFO count/pointers = 0.
  - All outputs 0: dct_valid, dct_sob, dct_eob, dct_sof, dct_data, req_ready, ret_ch, tag_err, busy.
  - A partial block is dropped. Sources must restart at row 0 after reset.

Optional Feature:
- Macro DCT_ARB_STRICT_PRIO_EN.
- Defined: fixed priority, lowest index wins (channel 0 highest). rr_ptr is not implemented.
- Undefined: round robin as above.
- Block-level atomicity and tag handling are identical in both builds.

Test Plan:
- Single channel: ch1 sends 8 rows with req_sof=1, no stalls -> dct_valid for 8 consecutive cycles starting 1 cycle after the first accept. sob on row 0 only, eob on row 7 only, sof=1 on row 0. Tag FIFO holds 1. On ret_sob, ret_ch=1 for all 8 returned rows.
- Contention: ch0, ch1 and ch2 all valid continuously from reset -> grant order 0,1,2,0. With STRICT_PRIO defined -> order 0,0,0.
- Mid-block stall: ch2 drops valid after row 3 for 5 cycles while ch0 is valid -> req_ready[0] stays 0, and rows 4..7 of ch2 follow contiguously in block order.
- Tag full: TAG_DEPTH=4, ret_valid held 0, all channels valid -> exactly 4 blocks granted, then req_ready=0. The first ret_sob frees a slot, and the 5th block starts 2 cycles later.
- Simultaneous push/pop: row-0 accept in the same cycle as ret_sob with count=2 -> count stays 2, and ret_ch equals the oldest tag.
- Reset mid-block: assert rst after row 4 -> all outputs 0 immediately, tag FIFO empty. ret_sob after deassertion sets tag_err=1. Next grant goes to ch0.
